// File: rtl/seg_display_arbiter.sv
// Shares an 8-digit common-anode 7-segment display between NUM_SRC requesters.
// Runs its own digit scan and hands the display out round-robin with a minimum
// hold, switching owner and latched value only at frame boundaries.
module seg_display_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned SCAN_DIV    = 25000,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     req,
    input  logic [32*NUM_SRC-1:0]  data,
    output logic [NUM_SRC-1:0]     grant,
    output logic [2:0]             cur_src,
    output logic                   frame_tick,
    output logic [7:0]             dig,
    output logic [7:0]             segm
);

    localparam int unsigned PresW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HoldW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [PresW-1:0] PrescMax = PresW'(SCAN_DIV - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_FRAMES - 1);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    state_e            state_q, state_d;
    logic [PresW-1:0]  presc_q, presc_d;
    logic [2:0]        idx_q, idx_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [2:0]        ptr_q, ptr_d;
    logic              frame_tick_q;
    logic [7:0]        dig_q, dig_d;
    logic [7:0]        segm_q, segm_d;

    logic              tick;
    logic              frame_end;
    logic [NUM_SRC-1:0] own_oh;
    logic [NUM_SRC-1:0] cand_req;
    logic              own_req;
    logic              win_found;
    logic [2:0]        win_idx;
    logic              load;
    logic [31:0]       load_data;

    // Active-low segment pattern for one hex nibble, dp always off.
    function automatic logic [7:0] enc(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick      = (presc_q == PrescMax);
    assign frame_end = tick && (idx_q == 3'd7);

    // Scan prescaler and digit sequencer; scanning never stops, even when idle.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
    end

    // One-hot of the current pointer; while showing, the pointer is the owner.
    always_comb begin
        own_oh = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            own_oh[i] = (ptr_q == 3'(i));
        end
    end

    // The owner never wins its own search, so a rotation always moves on.
    assign cand_req = (state_q == StShow) ? (req & ~own_oh) : req;
    assign own_req  = |(req & own_oh);

    // Round-robin search: first requester starting just after the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!win_found && cand_req[i] &&
                    (i == (int'(ptr_q) + k) % int'(NUM_SRC))) begin
                    win_found = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
    end

    // Arbitration FSM, evaluated only at frame end.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        load    = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_d = StShow;
                        ptr_d   = win_idx;
                        hold_d  = '0;
                        load    = 1'b1;
                    end
                end
                StShow: begin
                    if (!own_req) begin
                        if (win_found) begin
                            ptr_d  = win_idx;
                            hold_d = '0;
                            load   = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (hold_q == HoldMax) begin
                        if (win_found) begin
                            ptr_d = win_idx;
                        end
                        hold_d = '0;
                        load   = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                        load   = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Value latched for the next frame comes from whoever owns it next.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ptr_d == 3'(i)) begin
                load_data = data[32*i +: 32];
            end
        end
    end

    assign shadow_d = load ? load_data : shadow_q;

    // Pin drive for the current digit slot; blank segments while idle.
    always_comb begin
        dig_d  = ~(8'b1 << idx_q);
        segm_d = (state_q == StShow) ? enc(shadow_q[{idx_q, 2'b00} +: 4]) : 8'hFF;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            shadow_q     <= '0;
            ptr_q        <= 3'(NUM_SRC - 1);
            frame_tick_q <= 1'b0;
            dig_q        <= 8'hFF;
            segm_q       <= 8'hFF;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            hold_q       <= hold_d;
            shadow_q     <= shadow_d;
            ptr_q        <= ptr_d;
            frame_tick_q <= frame_end;
            dig_q        <= dig_d;
            segm_q       <= segm_d;
        end
    end

    assign grant      = (state_q == StShow) ? own_oh : '0;
    assign cur_src    = (state_q == StShow) ? ptr_q : 3'd0;
    assign frame_tick = frame_tick_q;
    assign dig        = dig_q;
    assign segm       = segm_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter: one table row per display frame.
module tb_seg_display_arbiter;

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'h9ABC_DEF0;
    localparam logic [31:0] D2 = 32'h0F1E_2D3C;
    localparam logic [31:0] D3 = 32'hA5B6_C7D8;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [31:0]  d0;
    logic [127:0] data;
    logic [3:0]   grant;
    logic [2:0]   cur_src;
    logic         frame_tick;
    logic [7:0]   dig;
    logic [7:0]   segm;

    int tests;
    int fails;

    assign data = {D3, D2, D1, d0};

    seg_display_arbiter #(
        .NUM_SRC    (4),
        .SCAN_DIV   (4),
        .HOLD_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .grant     (grant),
        .cur_src   (cur_src),
        .frame_tick(frame_tick),
        .dig       (dig),
        .segm      (segm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame: req at start, req_glitch for digits 2..4, req_end from digit 5 on;
    // d0 at start, d0_mid from digit 4 on; shown/show describe this frame's display;
    // exp_grant is the owner after this frame's end.
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  req_glitch;
        logic [3:0]  req_end;
        logic [31:0] d0;
        logic [31:0] d0_mid;
        logic [31:0] shown;
        logic        show;
        logic [3:0]  exp_grant;
    } row_t;

    row_t rows [24];

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] idx_of(input logic [3:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string nm, input int n, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (row %0d): got %h, expected %h", nm, n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int n);
        row_t r;
        logic [7:0] exp_dig;
        logic [7:0] exp_seg;
        r   = rows[n];
        req = r.req;
        d0  = r.d0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) check("frame_tick_low", n, 32'(frame_tick), 32'd0);
            exp_dig = ~(8'b1 << k);
            exp_seg = r.show ? seg_of(r.shown[4*k +: 4]) : 8'hFF;
            check("dig", n, 32'(dig), 32'(exp_dig));
            check("segm", n, 32'(segm), 32'(exp_seg));
            if (k == 2) req = r.req_glitch;
            if (k == 4) d0 = r.d0_mid;
            if (k == 5) req = r.req_end;
            repeat (3) step();
        end
        check("frame_tick_high", n, 32'(frame_tick), 32'd1);
        check("grant", n, 32'(grant), 32'(r.exp_grant));
        check("cur_src", n, 32'(cur_src), 32'(idx_of(r.exp_grant)));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //        req      glitch   end      d0            d0_mid        shown         show  grant
        rows[0]  = '{4'b0000, 4'b0000, 4'b0000, D0,           D0,           32'h0,        1'b0, 4'b0000};
        rows[1]  = '{4'b0001, 4'b0001, 4'b0001, D0,           D0,           32'h0,        1'b0, 4'b0001};
        rows[2]  = '{4'b0001, 4'b0001, 4'b0001, D0,           D0,           D0,           1'b1, 4'b0001};
        rows[3]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D0,           1'b1, 4'b0010};
        rows[4]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D1,           1'b1, 4'b0010};
        rows[5]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D1,           1'b1, 4'b0100};
        rows[6]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D2,           1'b1, 4'b0100};
        rows[7]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D2,           1'b1, 4'b1000};
        rows[8]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D3,           1'b1, 4'b1000};
        rows[9]  = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D3,           1'b1, 4'b0001};
        rows[10] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D0,           1'b1, 4'b0001};
        rows[11] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D0,           1'b1, 4'b0010};
        rows[12] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D1,           1'b1, 4'b0010};
        rows[13] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D1,           1'b1, 4'b0100};
        rows[14] = '{4'b1111, 4'b1111, 4'b1001, D0,           D0,           D2,           1'b1, 4'b1000};
        rows[15] = '{4'b0000, 4'b0000, 4'b0000, D0,           D0,           D3,           1'b1, 4'b0000};
        rows[16] = '{4'b0000, 4'b0010, 4'b0000, D0,           D0,           32'h0,        1'b0, 4'b0000};
        rows[17] = '{4'b0001, 4'b0001, 4'b0001, 32'h0,        32'h0,        32'h0,        1'b0, 4'b0001};
        rows[18] = '{4'b0001, 4'b0001, 4'b0001, 32'h0,        32'hFFFF_FFFF, 32'h0,       1'b1, 4'b0001};
        rows[19] = '{4'b0001, 4'b0001, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b0001};
        rows[20] = '{4'b0001, 4'b0001, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b0001};
        // after a mid-frame reset
        rows[21] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           32'h0,        1'b0, 4'b0001};
        rows[22] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D0,           1'b1, 4'b0001};
        rows[23] = '{4'b1111, 4'b1111, 4'b1111, D0,           D0,           D0,           1'b1, 4'b0010};

        // Power-on reset with a real falling edge.
        rst_n = 1'b1;
        req   = 4'b0000;
        d0    = D0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_dig", -1, 32'(dig), 32'hFF);
        check("rst_segm", -1, 32'(segm), 32'hFF);
        check("rst_grant", -1, 32'(grant), 32'h0);
        check("rst_cur_src", -1, 32'(cur_src), 32'h0);
        check("rst_frame_tick", -1, 32'(frame_tick), 32'h0);
        @(posedge clk);
        #7 rst_n = 1'b1;

        for (int n = 0; n <= 20; n++) run_row(n);

        // Reset pulsed mid-frame while src0 is showing.
        req = 4'b1111;
        d0  = D0;
        repeat (10) step();
        check("pre_reset_grant", 21, 32'(grant), 32'b0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dig", 21, 32'(dig), 32'hFF);
        check("mid_rst_segm", 21, 32'(segm), 32'hFF);
        check("mid_rst_grant", 21, 32'(grant), 32'h0);
        check("mid_rst_cur_src", 21, 32'(cur_src), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_dig", 21, 32'(dig), 32'hFF);
        check("held_rst_frame_tick", 21, 32'(frame_tick), 32'h0);
        #3 rst_n = 1'b1;

        for (int n = 21; n <= 23; n++) run_row(n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the board's 8-digit, common-anode 7-segment display between NUM_SRC requesters, each offering a 32-bit hex value.
- Contains its own scan prescaler and digit sequencer.
- Grants the display round-robin, with a minimum hold of HOLD_FRAMES full frames per grant.
- Changes grant and displayed value only at frame boundaries, so every 8-digit frame shows one coherent value from one source.
- Sits between debug/status sources (CPU regs, PC, bus monitors) and the board's dig/segm pins.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
SCAN_DIV, 25000, clk cycles per digit slot
HOLD_FRAMES, 64, frames a grant is held before rotating to another pending requester

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_SRC  per-source display request, level
data  in  32*NUM_SRC  source i value at bits [32i+31:32i]
grant  out  NUM_SRC  one-hot current owner; all zero when idle
cur_src  out  3  index of granted source; 0 when idle
frame_tick  out  1  one-cycle pulse at each frame end
dig  out  8  digit enables, active-low, bit k = digit k
segm  out  8  segments, active-low, bit7 = dp, bits6..0 = g..a

Behaviour:
- Reset (async, rst_n=0), all values immediate:
  - prescaler=0, idx=0, hold=0, shadow=0, ptr=NUM_SRC-1
  - grant=0, cur_src=0, frame_tick=0, dig=8'hFF, segm=8'hFF
- Prescaler:
  - counts 0..SCAN_DIV-1 and wraps.
  - tick = (prescaler==SCAN_DIV-1), combinational.
- Digit index:
  - 3-bit idx increments on tick; wraps 7->0.
  - frame_end = tick && idx==7.
  - frame_tick is registered: high for the cycle after frame_end.
- Outputs:
  - dig and segm are registered from (idx, shadow, state), one cycle of latency after idx changes. Both update on the same edge, so there is no ghosting.
  - dig = ~(8'b1 << idx).
  - segm = enc(shadow[4idx+3:4idx]) in SHOW; 8'hFF (blank) in IDLE. Scanning continues in IDLE.
- enc (dp always off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
- Arbitration is evaluated only on frame_end:
  - RR search = first i with req[i]=1, scanning from ptr+1 mod NUM_SRC.
  - IDLE, any req -> SHOW: grant the RR winner, ptr=winner, hold=0, shadow=data[winner].
  - IDLE, no req -> stay IDLE.
  - SHOW, owner's req dropped, another req present -> grant the RR winner; ptr, hold, shadow as above.
  - SHOW, owner's req dropped, no req present -> IDLE; grant=0; shadow unchanged.
  - SHOW, owner still requesting, hold==HOLD_FRAMES-1, another source requesting -> rotate to the RR winner among the others. The owner is excluded; equivalently, the search starts at owner+1.
  - SHOW, owner still requesting, hold==HOLD_FRAMES-1, no other source requesting -> keep the owner; hold=0; shadow=data[owner].
  - SHOW, otherwise -> hold+1; shadow=data[owner] (live refresh once per frame).
- Grant timing:
  - Grant changes on the frame_end edge, the same edge on which idx wraps to 0.
  - The new shadow is therefore shown from digit 0 of the new frame.
- req toggling mid-frame has no effect until frame_end; glitches shorter than a frame are ignored.
- data changes mid-frame are not visible until the next frame.
- cur_src = encoded grant.
- Simultaneous requests resolve purely by RR order; no fixed priority.
- Reset asserted mid-frame returns every register to its reset value immediately. The first post-reset grant occurs at the first frame_end after release.

Test Plan:
(Bench uses NUM_SRC=4, SCAN_DIV=4, HOLD_FRAMES=2; frame = 32 cycles.)
1. Reset, no req -> dig sequence FE, FD, FB, ... 7F every 4 cycles; segm stays FF; grant=0; frame_tick every 32 cycles.
2. req=0001, data0=32'h1234_5678 -> at first frame_end, grant=0001. Next frame: digit 0 segm=80 ("8"), digit 1 F8 ("7"), ..., digit 7 F9 ("1").
3. req=1111 continuously, distinct data -> grant order 0001, 0010, 0100, 1000, 0001, each held for exactly 2 frames.
4. Owner src2 drops req mid-frame, req=1001 -> frame completes showing src2; at frame_end, grant=1000 (RR after ptr=2).
5. data0 changes mid-frame from 0 to 32'hFFFF_FFFF while src0 is sole owner -> current frame shows all C0; the next frame shows all 8E; hold wraps and grant stays 0001.
6. rst_n pulsed low mid-SHOW -> dig=FF, segm=FF, grant=0 asynchronously. After release, the first grant goes to src0 at the first frame_end.
